// File: rtl/gfx256_pixel_writer.sv
// -----------------------------------------------------------------------------
// gfx256_pixel_writer
//
// Final pixel stage of the gfx256 pipeline. Takes one finished pixel from the
// alpha blender, clips it against the target surface, optionally depth-tests
// it against a 16-bit z-buffer, and writes it as a byte-masked 256-bit line
// write through the wishbone master writer. The blender gets a one-cycle ack
// once the pixel has been written or discarded.
//
// Ports
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   target_base_i, zbuf_base_i color / z surface bases (32-byte line address)
//   target_size_x_i/_y_i       surface width / height in pixels
//   color_depth_i              00=8bpp, 01=16bpp, 1x=32bpp
//   zbuffer_enable_i           enables the depth test
//   pixel_*_i, write_i         pixel from the blender, valid on write_i
//   ack_o                      one-cycle done pulse to the blender
//   zbuf_*                     z-buffer line read port (request/ack)
//   wbm_*                      line write port (request/ack, busy)
// -----------------------------------------------------------------------------
module gfx256_pixel_writer #(
    parameter int POINT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [26:0]            target_base_i,
    input  logic [26:0]            zbuf_base_i,
    input  logic [POINT_WIDTH-1:0] target_size_x_i,
    input  logic [POINT_WIDTH-1:0] target_size_y_i,
    input  logic [1:0]             color_depth_i,
    input  logic                   zbuffer_enable_i,
    input  logic [POINT_WIDTH-1:0] pixel_x_i,
    input  logic [POINT_WIDTH-1:0] pixel_y_i,
    input  logic [POINT_WIDTH-1:0] pixel_z_i,
    input  logic [31:0]            pixel_color_i,
    input  logic                   write_i,
    output logic                   ack_o,
    output logic [26:0]            zbuf_addr_o,
    output logic                   zbuf_request_o,
    input  logic                   zbuf_ack_i,
    input  logic [255:0]           zbuf_data_i,
    output logic [26:0]            wbm_addr_o,
    output logic [255:0]           wbm_data_o,
    output logic [31:0]            wbm_sel_o,
    output logic                   wbm_request_o,
    input  logic                   wbm_ack_i,
    input  logic                   wbm_busy_i
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_ZRD  = 3'd2,
        ST_ZWR  = 3'd3,
        ST_CWR  = 3'd4,
        ST_ACK  = 3'd5
    } state_e;

    // ---------------------------------------------------------------- helpers

    // Byte offset of a pixel index for the given color depth (wraps at 32 bits).
    function automatic logic [31:0] color_offset(input logic [31:0] idx,
                                                 input logic [1:0]  depth);
        logic [31:0] off;
        case (depth)
            2'b00:   off = idx;
            2'b01:   off = {idx[30:0], 1'b0};
            default: off = {idx[29:0], 2'b00};
        endcase
        return off;
    endfunction

    // Color bytes placed at their byte lane within the 256-bit line.
    function automatic logic [255:0] color_line(input logic [31:0] color,
                                                input logic [1:0]  depth,
                                                input logic [4:0]  lane);
        logic [255:0] raw;
        case (depth)
            2'b00:   raw = {248'd0, color[7:0]};
            2'b01:   raw = {240'd0, color[15:0]};
            default: raw = {224'd0, color};
        endcase
        return raw << {lane, 3'b000};
    endfunction

    // Byte enables for a color write at the given lane.
    function automatic logic [31:0] color_sel(input logic [1:0] depth,
                                              input logic [4:0] lane);
        logic [31:0] raw;
        case (depth)
            2'b00:   raw = 32'h0000_0001;
            2'b01:   raw = 32'h0000_0003;
            default: raw = 32'h0000_000F;
        endcase
        return raw << lane;
    endfunction

    // 16-bit depth value placed at its half-word lane.
    function automatic logic [255:0] z_line(input logic [15:0] z,
                                            input logic [3:0]  zlane);
        return {240'd0, z} << {zlane, 4'b0000};
    endfunction

    // Byte enables for a z write at the given half-word lane.
    function automatic logic [31:0] z_sel(input logic [3:0] zlane);
        return 32'h0000_0003 << {zlane, 1'b0};
    endfunction

    // ---------------------------------------------------------------- state
    state_e                  state_q, state_d;
    logic [POINT_WIDTH-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic [POINT_WIDTH-1:0]  size_x_q, size_x_d, size_y_q, size_y_d;
    logic [31:0]             color_q, color_d;
    logic [26:0]             tbase_q, tbase_d, zbase_q, zbase_d;
    logic [1:0]              depth_q, depth_d;
    logic                    zen_q, zen_d;
    logic [26:0]             caddr_q, caddr_d, zline_q, zline_d;
    logic [4:0]              clane_q, clane_d;
    logic [3:0]              zlane_q, zlane_d;
    logic                    ack_q, ack_d;
    logic                    zreq_q, zreq_d;
    logic [26:0]             zaddr_q, zaddr_d;
    logic                    wreq_q, wreq_d;
    logic [26:0]             waddr_q, waddr_d;
    logic [255:0]            wdata_q, wdata_d;
    logic [31:0]             wsel_q, wsel_d;

    // ---------------------------------------------------------------- address math
    logic [31:0] idx_s, coff_s, zoff_s;
    logic [26:0] caddr_s, zline_s;
    logic [4:0]  clane_s;
    logic [3:0]  zlane_s;
    logic        clip_s;
    logic [15:0] stored_z_s;
    logic        z_pass_s;

    assign idx_s      = 32'(y_q) * 32'(size_x_q) + 32'(x_q);
    assign coff_s     = color_offset(idx_s, depth_q);
    assign zoff_s     = {idx_s[30:0], 1'b0};
    assign caddr_s    = tbase_q + coff_s[31:5];
    assign clane_s    = coff_s[4:0];
    assign zline_s    = zbase_q + zoff_s[31:5];
    assign zlane_s    = zoff_s[4:1];
    assign clip_s     = (x_q >= size_x_q) || (y_q >= size_y_q);
    assign stored_z_s = zbuf_data_i[{zlane_q, 4'b0000} +: 16];
    // Strictly nearer pixels win; equal depth keeps the stored pixel.
    assign z_pass_s   = $signed(16'(z_q)) > $signed(stored_z_s);

    // Next-state, capture and request/output logic for the pixel FSM.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        size_x_d = size_x_q;
        size_y_d = size_y_q;
        color_d  = color_q;
        tbase_d  = tbase_q;
        zbase_d  = zbase_q;
        depth_d  = depth_q;
        zen_d    = zen_q;
        caddr_d  = caddr_q;
        clane_d  = clane_q;
        zline_d  = zline_q;
        zlane_d  = zlane_q;
        ack_d    = 1'b0;
        zreq_d   = zreq_q;
        zaddr_d  = zaddr_q;
        wreq_d   = wreq_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        wsel_d   = wsel_q;

        case (state_q)
            ST_IDLE: begin
                if (write_i) begin
                    x_d      = pixel_x_i;
                    y_d      = pixel_y_i;
                    z_d      = pixel_z_i;
                    color_d  = pixel_color_i;
                    size_x_d = target_size_x_i;
                    size_y_d = target_size_y_i;
                    tbase_d  = target_base_i;
                    zbase_d  = zbuf_base_i;
                    depth_d  = color_depth_i;
                    zen_d    = zbuffer_enable_i;
                    state_d  = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CALC: begin
                caddr_d = caddr_s;
                clane_d = clane_s;
                zline_d = zline_s;
                zlane_d = zlane_s;
                // The first request is raised straight out of CALC so that it
                // is visible in the cycle the request state is entered.
                if (clip_s) begin
                    ack_d   = 1'b1;
                    state_d = ST_ACK;
                end else if (zen_q) begin
                    state_d = ST_ZRD;
                    if (!wbm_busy_i) begin
                        zreq_d  = 1'b1;
                        zaddr_d = zline_s;
                    end else begin
                        zreq_d  = 1'b0;
                    end
                end else begin
                    state_d = ST_CWR;
                    if (!wbm_busy_i) begin
                        wreq_d  = 1'b1;
                        waddr_d = caddr_s;
                        wdata_d = color_line(color_q, depth_q, clane_s);
                        wsel_d  = color_sel(depth_q, clane_s);
                    end else begin
                        wreq_d  = 1'b0;
                    end
                end
            end

            ST_ZRD: begin
                if (zreq_q) begin
                    if (zbuf_ack_i) begin
                        zreq_d = 1'b0;
                        if (z_pass_s) begin
                            state_d = ST_ZWR;
                        end else begin
                            ack_d   = 1'b1;
                            state_d = ST_ACK;
                        end
                    end else begin
                        zreq_d = 1'b1;
                    end
                end else if (!wbm_busy_i) begin
                    zreq_d  = 1'b1;
                    zaddr_d = zline_q;
                end else begin
                    zreq_d = 1'b0;
                end
            end

            ST_ZWR: begin
                if (wreq_q) begin
                    if (wbm_ack_i) begin
                        wreq_d  = 1'b0;
                        state_d = ST_CWR;
                    end else begin
                        wreq_d = 1'b1;
                    end
                end else if (!wbm_busy_i) begin
                    wreq_d  = 1'b1;
                    waddr_d = zline_q;
                    wdata_d = z_line(16'(z_q), zlane_q);
                    wsel_d  = z_sel(zlane_q);
                end else begin
                    wreq_d = 1'b0;
                end
            end

            ST_CWR: begin
                if (wreq_q) begin
                    if (wbm_ack_i) begin
                        wreq_d  = 1'b0;
                        ack_d   = 1'b1;
                        state_d = ST_ACK;
                    end else begin
                        wreq_d = 1'b1;
                    end
                end else if (!wbm_busy_i) begin
                    wreq_d  = 1'b1;
                    waddr_d = caddr_q;
                    wdata_d = color_line(color_q, depth_q, clane_q);
                    wsel_d  = color_sel(depth_q, clane_q);
                end else begin
                    wreq_d = 1'b0;
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                zreq_d  = 1'b0;
                wreq_d  = 1'b0;
            end
        endcase
    end

    // State, captured pixel and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            size_x_q <= '0;
            size_y_q <= '0;
            color_q  <= 32'd0;
            tbase_q  <= 27'd0;
            zbase_q  <= 27'd0;
            depth_q  <= 2'd0;
            zen_q    <= 1'b0;
            caddr_q  <= 27'd0;
            clane_q  <= 5'd0;
            zline_q  <= 27'd0;
            zlane_q  <= 4'd0;
            ack_q    <= 1'b0;
            zreq_q   <= 1'b0;
            zaddr_q  <= 27'd0;
            wreq_q   <= 1'b0;
            waddr_q  <= 27'd0;
            wdata_q  <= 256'd0;
            wsel_q   <= 32'd0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            size_x_q <= size_x_d;
            size_y_q <= size_y_d;
            color_q  <= color_d;
            tbase_q  <= tbase_d;
            zbase_q  <= zbase_d;
            depth_q  <= depth_d;
            zen_q    <= zen_d;
            caddr_q  <= caddr_d;
            clane_q  <= clane_d;
            zline_q  <= zline_d;
            zlane_q  <= zlane_d;
            ack_q    <= ack_d;
            zreq_q   <= zreq_d;
            zaddr_q  <= zaddr_d;
            wreq_q   <= wreq_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            wsel_q   <= wsel_d;
        end
    end

    assign ack_o          = ack_q;
    assign zbuf_request_o = zreq_q;
    assign zbuf_addr_o    = zaddr_q;
    assign wbm_request_o  = wreq_q;
    assign wbm_addr_o     = waddr_q;
    assign wbm_data_o     = wdata_q;
    assign wbm_sel_o      = wsel_q;

endmodule
